// File: rtl/alu_issue_stage_if.sv
// Bundle between the ID stage, the forwarding sources and the ALU inputs of alu_issue_stage.
// The master side drives the decoded ID fields and forwarding data; the slave side is the issue stage.
interface alu_issue_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          id_valid;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [RW-1:0] id_rs_addr;
  logic [RW-1:0] id_rt_addr;
  logic [RW-1:0] id_rd_addr;
  logic [15:0]   id_imm16;
  logic [4:0]    id_shamt;
  logic [5:0]    id_alufun;
  logic          id_sign;
  logic          id_alusrc_a;
  logic          id_alusrc_b;
  logic          id_ext_op;
  logic          id_lui;
  logic          id_regwrite;
  logic          id_memread;
  logic          exmem_regwrite;
  logic [RW-1:0] exmem_rd;
  logic [DW-1:0] exmem_result;
  logic          memwb_regwrite;
  logic [RW-1:0] memwb_rd;
  logic [DW-1:0] memwb_result;
  logic [DW-1:0] ex_A;
  logic [DW-1:0] ex_B;
  logic [5:0]    ex_alufun;
  logic          ex_sign;
  logic [DW-1:0] ex_store_data;
  logic [RW-1:0] ex_rd;
  logic          ex_regwrite;
  logic          ex_memread;
  logic          ex_valid;
  logic          load_use_hazard;

  modport master (
    output id_valid, id_rs_data, id_rt_data, id_rs_addr, id_rt_addr, id_rd_addr,
           id_imm16, id_shamt, id_alufun, id_sign, id_alusrc_a, id_alusrc_b,
           id_ext_op, id_lui, id_regwrite, id_memread,
           exmem_regwrite, exmem_rd, exmem_result, memwb_regwrite, memwb_rd, memwb_result,
    input  ex_A, ex_B, ex_alufun, ex_sign, ex_store_data, ex_rd,
           ex_regwrite, ex_memread, ex_valid, load_use_hazard
  );

  modport slave (
    input  id_valid, id_rs_data, id_rt_data, id_rs_addr, id_rt_addr, id_rd_addr,
           id_imm16, id_shamt, id_alufun, id_sign, id_alusrc_a, id_alusrc_b,
           id_ext_op, id_lui, id_regwrite, id_memread,
           exmem_regwrite, exmem_rd, exmem_result, memwb_regwrite, memwb_rd, memwb_result,
    output ex_A, ex_B, ex_alufun, ex_sign, ex_store_data, ex_rd,
           ex_regwrite, ex_memread, ex_valid, load_use_hazard
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX register plus EX operand resolution (forwarding, immediates, shift amount) and load-use detect.
// Optional macro ALU_FWD_EN enables EX/MEM and MEM/WB forwarding and the stall-time data refresh.
module alu_issue_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input logic              clk,
  input logic              reset,
  input logic              stall,
  input logic              flush,
  alu_issue_stage_if.slave bus
);

  typedef struct packed {
    logic          valid;
    logic          regwrite;
    logic          memread;
    logic          sign;
    logic          alusrc_a;
    logic          alusrc_b;
    logic          ext;
    logic          lui;
    logic [5:0]    alufun;
    logic [RW-1:0] rd;
    logic [4:0]    shamt;
    logic [15:0]   imm;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
  } ex_t;

  ex_t           ex_r;
  logic [DW-1:0] fwd_rs_s;
  logic [DW-1:0] fwd_rt_s;
  logic [DW-1:0] a_s;
  logic [DW-1:0] b_s;
  logic          hazard_s;

`ifdef ALU_FWD_EN
  logic [RW-1:0] rs_addr_r;
  logic [RW-1:0] rt_addr_r;

  // EX/MEM beats MEM/WB on a double match; register 0 is never forwarded.
  function automatic logic [DW-1:0] fwd_pick(
    input logic [RW-1:0] src,
    input logic [DW-1:0] captured,
    input logic          em_we,
    input logic [RW-1:0] em_rd,
    input logic [DW-1:0] em_res,
    input logic          mw_we,
    input logic [RW-1:0] mw_rd,
    input logic [DW-1:0] mw_res
  );
    logic [DW-1:0] res;
    if (em_we && (em_rd != {RW{1'b0}}) && (em_rd == src)) begin
      res = em_res;
    end else if (mw_we && (mw_rd != {RW{1'b0}}) && (mw_rd == src)) begin
      res = mw_res;
    end else begin
      res = captured;
    end
    return res;
  endfunction

  // Source register addresses, kept only for forwarding comparison.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_addr_r <= {RW{1'b0}};
      rt_addr_r <= {RW{1'b0}};
    end else if (flush) begin
      rs_addr_r <= {RW{1'b0}};
      rt_addr_r <= {RW{1'b0}};
    end else if (!stall) begin
      rs_addr_r <= bus.id_rs_addr;
      rt_addr_r <= bus.id_rt_addr;
    end
  end

  // Forwarded source operands.
  always_comb begin
    fwd_rs_s = fwd_pick(rs_addr_r, ex_r.rs_data, bus.exmem_regwrite, bus.exmem_rd,
                        bus.exmem_result, bus.memwb_regwrite, bus.memwb_rd, bus.memwb_result);
    fwd_rt_s = fwd_pick(rt_addr_r, ex_r.rt_data, bus.exmem_regwrite, bus.exmem_rd,
                        bus.exmem_result, bus.memwb_regwrite, bus.memwb_rd, bus.memwb_result);
  end
`else
  // Without forwarding the captured register-file data is used as-is.
  always_comb begin
    fwd_rs_s = ex_r.rs_data;
    fwd_rt_s = ex_r.rt_data;
  end
`endif

  // ID/EX register: flush beats stall beats load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_r <= '0;
    end else if (flush) begin
      ex_r <= '0;
    end else if (stall) begin
`ifdef ALU_FWD_EN
      // Refresh so a result retiring from MEM/WB during the stall is not lost.
      ex_r.rs_data <= fwd_rs_s;
      ex_r.rt_data <= fwd_rt_s;
`endif
    end else begin
      ex_r <= '{
        valid:    bus.id_valid,
        regwrite: bus.id_regwrite,
        memread:  bus.id_memread,
        sign:     bus.id_sign,
        alusrc_a: bus.id_alusrc_a,
        alusrc_b: bus.id_alusrc_b,
        ext:      bus.id_ext_op,
        lui:      bus.id_lui,
        alufun:   bus.id_alufun,
        rd:       bus.id_rd_addr,
        shamt:    bus.id_shamt,
        imm:      bus.id_imm16,
        rs_data:  bus.id_rs_data,
        rt_data:  bus.id_rt_data
      };
    end
  end

  // Operand selection and load-use detection.
  always_comb begin
    if (ex_r.alusrc_a) begin
      a_s = {{(DW-5){1'b0}}, ex_r.shamt};
    end else begin
      a_s = fwd_rs_s;
    end

    if (!ex_r.alusrc_b) begin
      b_s = fwd_rt_s;
    end else if (ex_r.lui) begin
      b_s = {ex_r.imm, {(DW-16){1'b0}}};
    end else if (ex_r.ext) begin
      b_s = {{(DW-16){ex_r.imm[15]}}, ex_r.imm};
    end else begin
      b_s = {{(DW-16){1'b0}}, ex_r.imm};
    end

    if (ex_r.memread && ex_r.valid && bus.id_valid && (ex_r.rd != {RW{1'b0}}) &&
        ((ex_r.rd == bus.id_rs_addr) || (ex_r.rd == bus.id_rt_addr))) begin
      hazard_s = 1'b1;
    end else begin
      hazard_s = 1'b0;
    end
  end

  assign bus.ex_A            = a_s;
  assign bus.ex_B            = b_s;
  assign bus.ex_store_data   = fwd_rt_s;
  assign bus.ex_alufun       = ex_r.alufun;
  assign bus.ex_sign         = ex_r.sign;
  assign bus.ex_rd           = ex_r.rd;
  assign bus.ex_regwrite     = ex_r.regwrite;
  assign bus.ex_memread      = ex_r.memread;
  assign bus.ex_valid        = ex_r.valid;
  assign bus.load_use_hazard = hazard_s;

endmodule
